// File: rtl/dbg_router_pkg.sv
// Shared debug package: segment/address types, decode constants and router state.
package dbg_router_pkg;

  typedef enum logic [1:0] {
    SEG_CTL = 2'd0,
    SEG_ROM = 2'd1,
    SEG_RAM = 2'd2,
    SEG_IO  = 2'd3
  } seg_t;

  typedef struct packed {
    seg_t        seg;
    logic [11:0] off;
  } addr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam int Dbg_data_width = 8;
  localparam int Cnt_width      = 10;

  localparam logic [11:0] Ctl_reg_lo    = 12'h004;
  localparam logic [11:0] Ctl_reg_hi    = 12'h006;
  localparam logic [11:0] Ctl_blk_lo    = 12'h008;
  localparam logic [11:0] Ctl_addr_high = 12'h010;

  localparam logic [11:0] Io_win_mask = 12'hFF8;
  localparam logic [11:0] Io_win_rw   = 12'h000;
  localparam logic [11:0] Io_win_ro0  = 12'h010;
  localparam logic [11:0] Io_win_ro1  = 12'h020;

  function automatic logic [3:0] seg_onehot(input seg_t s);
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/dbg_router_if.sv
// Debug router bus: upstream request/response channel plus shared segment port.
interface dbg_router_if;
  import dbg_router_pkg::*;

  // Request and response are valid/ready channels: a beat transfers on the rising
  // clk edge where valid and ready are both high; the sender holds valid and its
  // payload stable until that edge, and ready may not depend on a future valid.
  logic                                  req_valid;
  logic                                  req_ready;
  logic [13:0]                           req_addr;
  logic                                  req_write;
  logic [Dbg_data_width-1:0]             req_wdata;
  logic                                  resp_valid;
  logic                                  resp_ready;
  logic [Dbg_data_width-1:0]             resp_rdata;
  logic                                  resp_err;
  logic [3:0]                            seg_req;
  logic [11:0]                           seg_addr;
  logic                                  seg_write;
  logic [Dbg_data_width-1:0]             seg_wdata;
  logic [3:0]                            seg_ack;
  logic [3:0][Dbg_data_width-1:0]        seg_rdata;

  modport master (
    output req_valid, req_addr, req_write, req_wdata, resp_ready, seg_ack, seg_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           seg_req, seg_addr, seg_write, seg_wdata
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_wdata, resp_ready, seg_ack, seg_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           seg_req, seg_addr, seg_write, seg_wdata
  );

endinterface

// File: rtl/dbg_router_addr_check.sv
// Address legality decode for debug requests (combinational).
module dbg_addr_check
  import dbg_router_pkg::*;
(
  input  addr_t i_addr,
  input  logic  i_write,
  output logic  o_legal
);

  logic [11:0] w_io_win;
  assign w_io_win = i_addr.off & Io_win_mask;

  always_comb begin
    o_legal = 1'b0;
    case (i_addr.seg)
      SEG_CTL: o_legal = (i_addr.off == 12'h000) ||
                         ((i_addr.off >= Ctl_reg_lo) && (i_addr.off <= Ctl_reg_hi)) ||
                         ((i_addr.off >= Ctl_blk_lo) && (i_addr.off <= Ctl_addr_high));
      SEG_ROM: o_legal = 1'b1;
      SEG_RAM: o_legal = 1'b1;
      SEG_IO: begin
        // Upper two IO windows are status-only; writes there decode as errors.
        if (w_io_win == Io_win_rw)
          o_legal = 1'b1;
        else if ((w_io_win == Io_win_ro0) || (w_io_win == Io_win_ro1))
          o_legal = !i_write;
      end
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/dbg_router.sv
// Debug request router: decodes a request, issues it to one segment, waits for ack or timeout.
module dbg_router
  import dbg_router_pkg::*;
#(
  parameter int Timeout_cycles = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  dbg_router_if.slave  bus,
  output state_t       o_dbg_state
);

  localparam logic [Cnt_width-1:0] Tmo_limit = Cnt_width'(Timeout_cycles);

  state_t                    r_state;
  logic [Cnt_width-1:0]      r_cnt;
  seg_t                      r_seg;
  logic                      r_req_ready;
  logic                      r_resp_valid;
  logic [Dbg_data_width-1:0] r_rdata;
  logic                      r_err;
  logic [3:0]                r_seg_req;
  logic [11:0]               r_seg_addr;
  logic                      r_seg_write;
  logic [Dbg_data_width-1:0] r_seg_wdata;

  addr_t                     w_req_addr;
  logic                      w_legal;
  logic                      w_accept;
  logic                      w_ack;
  logic [Dbg_data_width-1:0] w_ack_data;

  assign w_req_addr = addr_t'(bus.req_addr);
  assign w_accept   = bus.req_valid & r_req_ready;
  // Only the segment currently requested may complete the transaction.
  assign w_ack      = |(bus.seg_ack & r_seg_req);
  assign w_ack_data = bus.seg_rdata[r_seg];

  dbg_addr_check u_addr_check (
    .i_addr  (w_req_addr),
    .i_write (bus.req_write),
    .o_legal (w_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_seg        <= SEG_CTL;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_seg_req    <= '0;
      r_seg_addr   <= '0;
      r_seg_write  <= 1'b0;
      r_seg_wdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_seg       <= w_req_addr.seg;
            r_seg_addr  <= w_req_addr.off;
            r_seg_write <= bus.req_write;
            r_seg_wdata <= bus.req_wdata;
            r_rdata     <= '0;
            if (w_legal) begin
              r_seg_req <= seg_onehot(w_req_addr.seg);
              r_cnt     <= Cnt_width'(1);
              r_err     <= 1'b0;
              r_state   <= ST_ISSUE;
            end else begin
              r_err        <= 1'b1;
              r_resp_valid <= 1'b1;
              r_state      <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          // Ack is tested first so a completion on the last allowed cycle still wins.
          if (w_ack) begin
            r_seg_req    <= '0;
            r_rdata      <= r_seg_write ? '0 : w_ack_data;
            r_err        <= 1'b0;
            r_resp_valid <= 1'b1;
            r_cnt        <= '0;
            r_state      <= ST_RESP;
          end else if (r_cnt == Tmo_limit) begin
            r_seg_req    <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b1;
            r_resp_valid <= 1'b1;
            r_cnt        <= '0;
            r_state      <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + Cnt_width'(1);
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
  assign bus.seg_req    = r_seg_req;
  assign bus.seg_addr   = r_seg_addr;
  assign bus.seg_write  = r_seg_write;
  assign bus.seg_wdata  = r_seg_wdata;
  assign o_dbg_state    = r_state;

endmodule

// File: doc/dbg_router.md
DBG_ROUTER -- requirements
Module: dbg_router

Interface
REQ-001 SHALL have parameter Timeout_cycles, default 255, meaning ack-wait limit in clk cycles (range 1..1023).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  upstream debug request valid.
REQ-005 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-006 SHALL have port req_addr  input  14  debug address: [13:12] segment (CTL=0, ROM=1, RAM=2, IO=3), [11:0] segment address.
REQ-007 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_wdata  input  8  write data.
REQ-009 SHALL have port resp_valid  output  1  response valid.
REQ-010 SHALL have port resp_ready  input  1  upstream accepts response.
REQ-011 SHALL have port resp_rdata  output  8  read data (0 for writes and errors).
REQ-012 SHALL have port resp_err  output  1  decode error or timeout.
REQ-013 SHALL have port seg_req  output  4  one-hot segment request, bit index = segment code.
REQ-014 SHALL have port seg_addr  output  12  segment address, shared.
REQ-015 SHALL have port seg_write  output  1  shared write flag.
REQ-016 SHALL have port seg_wdata  output  8  shared write data.
REQ-017 SHALL have port seg_ack  input  4  per-segment completion pulse.
REQ-018 SHALL have port seg_rdata  input  4x8  per-segment read data, valid with its ack.

Function
REQ-019 SHALL implement FSM IDLE, ISSUE, RESP; req_ready high only in IDLE.
REQ-020 SHALL, on req_valid&req_ready, register addr/write/wdata and enter ISSUE if address legal, else enter RESP with resp_err=1 and no seg_req.
REQ-021 SHALL treat legal CTL addresses as 0x000, 0x004-0x006, 0x008-0x010; all ROM and RAM addresses legal; IO legal when (addr & 0xFF8) equals 0x000, 0x010 or 0x020.
REQ-022 SHALL treat writes to IO windows 0x010-0x017 and 0x020-0x027 as illegal (read-only).
REQ-023 SHALL, in ISSUE, hold exactly one seg_req bit plus stable seg_addr/seg_write/seg_wdata until ack or timeout.
REQ-024 SHALL ignore seg_ack bits of non-selected segments.
REQ-025 SHALL, on selected ack, capture seg_rdata (reads) into resp_rdata, resp_err=0, drop seg_req next cycle, enter RESP.
REQ-026 SHALL count ISSUE cycles from 1; at count = Timeout_cycles with no ack, drop seg_req, resp_err=1, resp_rdata=0, enter RESP.
REQ-027 SHALL give ack priority over timeout when both occur in the same cycle.
REQ-028 SHALL hold resp_valid and response fields stable in RESP until resp_ready, then return to IDLE.
REQ-029 SHALL yield latency: accept at cycle 0, seg_req high at cycle 1, ack at cycle N gives resp_valid at N+1; decode error gives resp_valid at cycle 1.
REQ-030 SHALL allow back-to-back transactions with one IDLE cycle minimum between responses and the next accept.

Reset
REQ-031 SHALL, while rst_n low (including mid-transaction), force state IDLE, counter 0, req_ready 0, resp_valid 0, resp_rdata 0, resp_err 0, seg_req 0, seg_addr 0, seg_write 0, seg_wdata 0.
REQ-032 SHALL assert req_ready the first cycle after rst_n deasserts.

Structure
REQ-033 SHALL place router state enum, Ctl_addr_high (0x010) and Dbg_data_width (8) in the shared debug package, reusing its seg_t, addr_t and Io_* constants.
REQ-034 SHALL use one combinational sub-module dbg_addr_check (inputs addr_t, write; output legal).

Verification
REQ-035 SHALL cover ROM read 0x1123, ack after 3 cycles with rdata 0xA5 -> seg_req=0010, resp_rdata=0xA5, resp_err=0, resp_valid 4 cycles after accept.
REQ-036 SHALL cover CTL read 0x0007 and IO write 0x3012 -> no seg_req, resp_err=1 one cycle after accept.
REQ-037 SHALL cover RAM write 0x2040 data 0x3C with no ack, Timeout_cycles=8 -> seg_req dropped after 8 cycles, resp_err=1, resp_rdata=0.
REQ-038 SHALL cover ack of CTL while IO selected, then IO ack with 0x0F on timeout cycle -> first ignored, resp_rdata=0x0F, resp_err=0.
REQ-039 SHALL cover resp_ready held low 5 cycles, then rst_n pulsed mid-ISSUE -> response stable while stalled; all outputs 0 during reset, req_ready=1 after.
